// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 VGA scan-out of a stored RGB image.
// Fetches one RAM word per pixel period and replicates it SCALE x SCALE.
module vga_frame_reader #(
  parameter int          IMG_W     = 100,
  parameter int          IMG_H     = 100,
  parameter int          SCALE     = 4,
  parameter int          BASE_ADDR = 0,
  parameter int          ADDR_W    = 16,
  parameter logic [23:0] BG_COLOR  = 24'h0,
  parameter int          H_VIS     = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_VIS     = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic [23:0]       rgb,
  output logic              h_sync,
  output logic              v_sync,
  output logic              vga_clk,
  output logic              blank_n,
  output logic              frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_IMG  = HW'(IMG_W * SCALE);
  localparam logic [HW-1:0] H_VEND = HW'(H_VIS);
  localparam logic [HW-1:0] HS_B   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_E   = HW'(H_VIS + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_IMG  = VW'(IMG_H * SCALE);
  localparam logic [VW-1:0] V_VEND = VW'(V_VIS);
  localparam logic [VW-1:0] VS_B   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_E   = VW'(V_VIS + V_FP + V_SYNC);

  localparam logic [SW-1:0]     SC_LAST = SW'(SCALE - 1);
  localparam logic [ADDR_W-1:0] A_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] A_ROW   = ADDR_W'(IMG_W);

  logic              ph_q;
  logic [HW-1:0]     hc_q;
  logic [VW-1:0]     vc_q;
  logic [SW-1:0]     sx_q;
  logic [SW-1:0]     sy_q;
  logic [ADDR_W-1:0] col_q;
  logic [ADDR_W-1:0] rbase_q;
  logic [ADDR_W-1:0] hold_q;
  logic [23:0]       rgb_q;
  logic              blank_q;
  logic              hs_q;
  logic              vs_q;

  logic              in_img;
  logic              vis;
  logic              fetch;
  logic [ADDR_W-1:0] cur_addr;

  assign in_img   = (hc_q < H_IMG) && (vc_q < V_IMG);
  assign vis      = (hc_q < H_VEND) && (vc_q < V_VEND);
  assign cur_addr = rbase_q + col_q;
  // rst gates the strobes so nothing is requested while held in reset
  assign fetch    = rst && !ph_q && in_img;

  assign mem_rd_en   = fetch;
  assign mem_addr    = fetch ? cur_addr : hold_q;
  assign frame_start = rst && !ph_q &&
                       (hc_q == '0) && (vc_q == '0);

  assign vga_clk = ph_q;
  assign rgb     = rgb_q;
  assign blank_n = blank_q;
  assign h_sync  = hs_q;
  assign v_sync  = vs_q;

  // scan counters, divider-free image coordinates and address hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ph_q    <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      col_q   <= '0;
      rbase_q <= A_BASE;
      hold_q  <= '0;
    end else begin
      ph_q <= ~ph_q;
      if (fetch) hold_q <= cur_addr;
      if (ph_q) begin
        if (hc_q == H_LAST) begin
          hc_q  <= '0;
          sx_q  <= '0;
          col_q <= '0;
          if (vc_q == V_LAST) begin
            vc_q    <= '0;
            sy_q    <= '0;
            rbase_q <= A_BASE;
          end else begin
            vc_q <= vc_q + 1'b1;
            if (vc_q < V_IMG) begin
              if (sy_q == SC_LAST) begin
                sy_q    <= '0;
                rbase_q <= rbase_q + A_ROW;
              end else begin
                sy_q <= sy_q + 1'b1;
              end
            end
          end
        end else begin
          hc_q <= hc_q + 1'b1;
          if (hc_q < H_IMG) begin
            if (sx_q == SC_LAST) begin
              sx_q  <= '0;
              col_q <= col_q + 1'b1;
            end else begin
              sx_q <= sx_q + 1'b1;
            end
          end
        end
      end
    end
  end

  // video outputs, all updated together where vga_clk falls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q   <= '0;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
    end else if (ph_q) begin
      if (in_img)   rgb_q <= mem_rdata;
      else if (vis) rgb_q <= BG_COLOR;
      else          rgb_q <= '0;
      blank_q <= vis;
      hs_q    <= !((hc_q >= HS_B) && (hc_q < HS_E));
      vs_q    <= !((vc_q >= VS_B) && (vc_q < VS_E));
    end
  end

endmodule
